z16_instr_ram: RTL and testbench

- Parametrised, writable, synchronous-read instruction memory for the Z16 core; replaces the fixed combinational program ROM.
- CPU fetch port: request/valid handshake, one-cycle read latency.
- Loader port: a debug/boot agent writes program words at run time.
- After reset, the memory clears itself to a fill word before accepting fetches or loads.

---
 rtl/z16_instr_ram.sv | 153 +++++++++++++++
 tb/tb_z16_instr_ram.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/z16_instr_ram.sv
// Z16 writable instruction memory: self-clearing, 1-cycle fetch, loader port.
// Optional Z16_IMEM_PARITY_EN adds a stored even-parity bit and o_parity_err.
module z16_instr_ram #(
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [15:0] FILL_WORD  = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        o_ready,
    output logic        o_valid,
    output logic [15:0] o_instr,
    output logic        o_fault,
    input  logic        i_ld_we,
    input  logic [15:0] i_ld_addr,
    input  logic [15:0] i_ld_data,
    output logic        o_ld_ack,
    output logic        o_ld_err
`ifdef Z16_IMEM_PARITY_EN
    ,
    output logic        o_parity_err
`endif
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
`ifdef Z16_IMEM_PARITY_EN
    localparam int MW = 17;
`else
    localparam int MW = 16;
`endif

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [MW-1:0]         mem_q [DEPTH];

    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_waddr;
    logic [15:0]           mem_wdata;
    logic                  fetch_acc;
    logic                  ld_acc;

    // Aligned and inside the array: bit 0 clear, nothing above the index.
    function automatic logic addr_ok(input logic [15:0] a);
        return (a[0] == 1'b0) && ((a >> (DEPTH_LOG2 + 1)) == 16'h0000);
    endfunction

    logic fetch_ok;
    logic ld_ok;
    assign fetch_ok = addr_ok(i_addr);
    assign ld_ok    = addr_ok(i_ld_addr);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = FILL_WORD;
        fetch_acc = 1'b0;
        ld_acc    = 1'b0;
        o_ready   = 1'b0;
        case (state_q)
            S_INIT: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                o_ready   = ~i_ld_we;
                fetch_acc = i_req & ~i_ld_we;
                ld_acc    = i_ld_we;
                if (i_ld_we && ld_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = i_ld_addr[DEPTH_LOG2:1];
                    mem_wdata = i_ld_data;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && mem_we) begin
`ifdef Z16_IMEM_PARITY_EN
            mem_q[mem_waddr] <= {^mem_wdata, mem_wdata};
`else
            mem_q[mem_waddr] <= mem_wdata;
`endif
        end
    end

    logic [MW-1:0] rd_word;
    logic          par_bad;
    assign rd_word = mem_q[i_addr[DEPTH_LOG2:1]];
`ifdef Z16_IMEM_PARITY_EN
    assign par_bad = (^rd_word[15:0]) != rd_word[16];
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid  <= 1'b0;
            o_instr  <= 16'h0000;
            o_fault  <= 1'b0;
            o_ld_ack <= 1'b0;
            o_ld_err <= 1'b0;
        end else begin
            o_valid  <= fetch_acc;
            o_ld_ack <= ld_acc;
            o_ld_err <= ld_acc & ~ld_ok;
            if (fetch_acc) begin
                if (!fetch_ok) begin
                    o_instr <= FILL_WORD;
                    o_fault <= 1'b1;
                end else begin
                    o_instr <= rd_word[15:0];
                    o_fault <= par_bad;
                end
            end
        end
    end

`ifdef Z16_IMEM_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_parity_err <= 1'b0;
        end else if (fetch_acc) begin
            o_parity_err <= fetch_ok & par_bad;
        end
    end
`endif

endmodule

// File: tb/tb_z16_instr_ram.sv
// Directed bench for z16_instr_ram (DEPTH_LOG2=8, FILL_WORD=16'h00FD).
// Parity checks are built only with Z16_IMEM_PARITY_EN defined.
module tb_z16_instr_ram;

    localparam logic [15:0] FILL = 16'h00FD;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_instr;
    logic        o_fault;
    logic        i_ld_we;
    logic [15:0] i_ld_addr;
    logic [15:0] i_ld_data;
    logic        o_ld_ack;
    logic        o_ld_err;
`ifdef Z16_IMEM_PARITY_EN
    logic        o_parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    z16_instr_ram #(
        .DEPTH_LOG2(8),
        .FILL_WORD (FILL)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_instr  (o_instr),
        .o_fault  (o_fault),
        .i_ld_we  (i_ld_we),
        .i_ld_addr(i_ld_addr),
        .i_ld_data(i_ld_data),
        .o_ld_ack (o_ld_ack),
        .o_ld_err (o_ld_err)
`ifdef Z16_IMEM_PARITY_EN
        ,
        .o_parity_err(o_parity_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Wait out INIT; drop the loader strobe after the first cycle.
    task automatic init_wait(output int cycles, output bit saw);
        cycles = 0;
        saw    = 1'b0;
        while (!o_ready && cycles < 1000) begin
            tick();
            i_ld_we = 1'b0;
            cycles++;
            if (o_valid || o_ld_ack) saw = 1'b1;
        end
    endtask

    task automatic fetch(input logic [15:0] a);
        i_req  = 1'b1;
        i_addr = a;
        tick();
        i_req  = 1'b0;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        i_ld_we   = 1'b1;
        i_ld_addr = a;
        i_ld_data = d;
        tick();
        i_ld_we   = 1'b0;
    endtask

    int cyc;
    bit saw;

    initial begin
        i_rst_n   = 1'b0;
        i_req     = 1'b0;
        i_addr    = 16'h0;
        i_ld_we   = 1'b0;
        i_ld_addr = 16'h0;
        i_ld_data = 16'h0;
        @(negedge i_clk);
        tick();
        check("rst_valid", o_valid, 0);
        check("rst_instr", o_instr, 0);
        check("rst_ready", o_ready, 0);
        check("rst_ack", o_ld_ack, 0);

        // Release with a fetch already pending: ignored until RUN.
        i_rst_n = 1'b1;
        i_req   = 1'b1;
        i_addr  = 16'h0010;
        init_wait(cyc, saw);
        check("init_cycles", cyc, 256);
        check("init_quiet", saw, 0);
        tick();
        i_req = 1'b0;
        check("f10_valid", o_valid, 1);
        check("f10_instr", o_instr, FILL);
        check("f10_fault", o_fault, 0);

        load(16'h0000, 16'h0010);
        check("ld0_ack", o_ld_ack, 1);
        check("ld0_err", o_ld_err, 0);
        load(16'h0002, 16'h0119);
        check("ld2_ack", o_ld_ack, 1);
        check("ld2_err", o_ld_err, 0);
        tick();
        check("ack_pulse", o_ld_ack, 0);

        i_req  = 1'b1;
        i_addr = 16'h0000;
        tick();
        check("b2b0_valid", o_valid, 1);
        check("b2b0_instr", o_instr, 16'h0010);
        i_addr = 16'h0002;
        tick();
        check("b2b1_valid", o_valid, 1);
        check("b2b1_instr", o_instr, 16'h0119);
        i_req = 1'b0;
        tick();
        check("idle_valid", o_valid, 0);
        check("idle_hold", o_instr, 16'h0119);

        fetch(16'h0003);
        check("mis_valid", o_valid, 1);
        check("mis_fault", o_fault, 1);
        check("mis_instr", o_instr, FILL);
        fetch(16'h0200);
        check("oor_fault", o_fault, 1);
        check("oor_instr", o_instr, FILL);
        fetch(16'h01FE);
        check("last_fault", o_fault, 0);
        check("last_instr", o_instr, FILL);
        load(16'h0201, 16'hDEAD);
        check("ldmis_ack", o_ld_ack, 1);
        check("ldmis_err", o_ld_err, 1);
        load(16'h0200, 16'hBEEF);
        check("ldoor_err", o_ld_err, 1);
        fetch(16'h0000);
        check("ldbad_nochg", o_instr, 16'h0010);

        // Loader wins a same-cycle collision; the fetch is not taken.
        i_req     = 1'b1;
        i_addr    = 16'h0006;
        i_ld_we   = 1'b1;
        i_ld_addr = 16'h0006;
        i_ld_data = 16'hBEEF;
        #1;
        check("prio_ready", o_ready, 0);
        tick();
        i_ld_we = 1'b0;
        check("prio_novalid", o_valid, 0);
        check("prio_ack", o_ld_ack, 1);
        tick();
        i_req = 1'b0;
        check("raw_valid", o_valid, 1);
        check("raw_instr", o_instr, 16'hBEEF);

        load(16'h0004, 16'h7A49);
        fetch(16'h0004);
        check("pre_rst", o_instr, 16'h7A49);
        i_req   = 1'b1;
        i_addr  = 16'h0004;
        i_rst_n = 1'b0;
        tick();
        i_req = 1'b0;
        check("mrst_valid", o_valid, 0);
        check("mrst_ready", o_ready, 0);
        i_rst_n   = 1'b1;
        i_ld_we   = 1'b1;
        i_ld_addr = 16'h0004;
        i_ld_data = 16'h1234;
        init_wait(cyc, saw);
        check("reinit_cycles", cyc, 256);
        check("reinit_quiet", saw, 0);
        fetch(16'h0004);
        check("reinit_instr", o_instr, FILL);
        fetch(16'h0000);
        check("reinit_w0", o_instr, FILL);

`ifdef Z16_IMEM_PARITY_EN
        load(16'h000A, 16'h1234);
        fetch(16'h000A);
        check("par_ok_fault", o_fault, 0);
        check("par_ok_err", o_parity_err, 0);
        dut.mem_q[5][16] = ~dut.mem_q[5][16];
        fetch(16'h000A);
        check("par_bad_err", o_parity_err, 1);
        check("par_bad_fault", o_fault, 1);
        check("par_bad_instr", o_instr, 16'h1234);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
